// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared request and grant types for the data-memory port arbiter
package dmem_arb_pkg;
  localparam int DMEM_AW = 5;
  localparam int DMEM_DW = 32;
  typedef struct packed {
    logic               valid;
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
  } dmem_req_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_R0, GNT_R1, GNT_BOTH} dmem_gnt_e;
endpackage

// File: rtl/dmem_arb_grant.sv
// dmem_arb_grant: combinational grant decision from two requests and the priority pointer
module dmem_arb_grant
  import dmem_arb_pkg::*;
(
  input  dmem_req_t r0,
  input  dmem_req_t r1,
  input  logic      prio,
  output dmem_gnt_e gnt,
  output logic      conflict
);
  logic unused_fields;
  assign unused_fields = ^{r0.addr, r0.wdata, r1.addr, r1.wdata};
  always_comb begin
    conflict = r0.valid && r1.valid && (r0.we || r1.we);
    gnt = !r0.valid ? (r1.valid ? GNT_R1 : GNT_NONE) :
          !r1.valid ? GNT_R0 :
          !conflict ? GNT_BOTH :
          prio      ? GNT_R1 : GNT_R0;
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the dual-port DataMemory between the LSU (r0) and the debug/DMA loader (r1)
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_AW,
  parameter int DATA_WIDTH = DMEM_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_resp_valid,
  output logic [DATA_WIDTH-1:0] r0_resp_rdata,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_resp_valid,
  output logic [DATA_WIDTH-1:0] r1_resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr1,
  output logic [ADDR_WIDTH-1:0] mem_addr2,
  output logic [DATA_WIDTH-1:0] mem_wd1,
  output logic [DATA_WIDTH-1:0] mem_wd2,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rd1,
  input  logic [DATA_WIDTH-1:0] mem_rd2
);
  dmem_req_t             req0, req1;
  dmem_gnt_e             gnt;
  logic                  conflict, wr0, wr1;
  logic                  prio_q, prio_d;
  logic                  r0_resp_valid_q, r0_resp_valid_d, r1_resp_valid_q, r1_resp_valid_d;
  logic [DATA_WIDTH-1:0] r0_resp_rdata_q, r0_resp_rdata_d, r1_resp_rdata_q, r1_resp_rdata_d;
  // Masking valids with rst keeps both ready and mem_we low while reset is held.
  assign req0 = '{valid: r0_valid && !rst, we: r0_we, addr: r0_addr, wdata: r0_wdata};
  assign req1 = '{valid: r1_valid && !rst, we: r1_we, addr: r1_addr, wdata: r1_wdata};
  dmem_arb_grant u_grant (
    .r0       (req0),
    .r1       (req1),
    .prio     (prio_q),
    .gnt      (gnt),
    .conflict (conflict)
  );
  assign r0_ready  = gnt == GNT_R0 || gnt == GNT_BOTH;
  assign r1_ready  = gnt == GNT_R1 || gnt == GNT_BOTH;
  assign wr0       = gnt == GNT_R0 && r0_we;
  assign wr1       = gnt == GNT_R1 && r1_we;
  assign mem_we    = wr0 || wr1;
  // A write drives its address onto both ports; a read uses only its own port.
  assign mem_addr1 = r0_ready ? r0_addr : wr1 ? r1_addr : '0;
  assign mem_addr2 = r1_ready ? r1_addr : wr0 ? r0_addr : '0;
  assign mem_wd1   = wr0 ? r0_wdata : wr1 ? r1_wdata : '0;
  assign mem_wd2   = mem_wd1;
  always_comb begin
    prio_d          = conflict ? !prio_q : prio_q;
    r0_resp_valid_d = r0_ready;
    r1_resp_valid_d = r1_ready;
    r0_resp_rdata_d = r0_ready ? (r0_we ? '0 : mem_rd1) : r0_resp_rdata_q;
    r1_resp_rdata_d = r1_ready ? (r1_we ? '0 : mem_rd2) : r1_resp_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q          <= 1'b0;
      r0_resp_valid_q <= 1'b0;
      r1_resp_valid_q <= 1'b0;
      r0_resp_rdata_q <= '0;
      r1_resp_rdata_q <= '0;
    end else begin
      prio_q          <= prio_d;
      r0_resp_valid_q <= r0_resp_valid_d;
      r1_resp_valid_q <= r1_resp_valid_d;
      r0_resp_rdata_q <= r0_resp_rdata_d;
      r1_resp_rdata_q <= r1_resp_rdata_d;
    end
  end
  assign r0_resp_valid = r0_resp_valid_q;
  assign r1_resp_valid = r1_resp_valid_q;
  assign r0_resp_rdata = r0_resp_rdata_q;
  assign r1_resp_rdata = r1_resp_rdata_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenarios plus randomized traffic against a request-level reference model
module tb_dmem_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  logic          clk = 1'b0;
  logic          rst;
  logic          r0_valid, r1_valid, r0_ready, r1_ready, r0_we, r1_we;
  logic [AW-1:0] r0_addr, r1_addr, mem_addr1, mem_addr2;
  logic [DW-1:0] r0_wdata, r1_wdata, r0_resp_rdata, r1_resp_rdata;
  logic [DW-1:0] mem_wd1, mem_wd2, mem_rd1, mem_rd2;
  logic          r0_resp_valid, r1_resp_valid, mem_we;
  logic [DW-1:0] mem [32];
  logic [DW-1:0] ref_mem [32];
  int            n_tests = 0;
  int            n_fail = 0;
  int            we_pulses = 0;

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_resp_valid(r0_resp_valid), .r0_resp_rdata(r0_resp_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_resp_valid(r1_resp_valid), .r1_resp_rdata(r1_resp_rdata),
    .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .mem_wd1(mem_wd1), .mem_wd2(mem_wd2),
    .mem_we(mem_we), .mem_rd1(mem_rd1), .mem_rd2(mem_rd2)
  );

  always #5 clk = ~clk;
  assign mem_rd1 = mem[mem_addr1];
  assign mem_rd2 = mem[mem_addr2];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr1] <= mem_wd1;
      mem[mem_addr2] <= mem_wd2;
      we_pulses      <= we_pulses + 1;
    end
  end

  task automatic drive(input bit v0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit v1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    r0_valid = v0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
    r1_valid = v1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1; drive(1, 1, 2, 32'h5, 1, 1, 4, 32'h6); #1;
    n_tests++;
    if (r0_ready !== 1'b0 || r1_ready !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got r0_ready=%b r1_ready=%b mem_we=%b, want 0 0 0", r0_ready, r1_ready, mem_we);
    end
    @(posedge clk); #1;
    n_tests++;
    if (r0_resp_valid !== 1'b0 || r1_resp_valid !== 1'b0 || r0_resp_rdata !== '0 || r1_resp_rdata !== '0) begin
      n_fail++; $display("FAIL reset_resp: got v=%b%b rd0=%h rd1=%h, want 00 0 0", r0_resp_valid, r1_resp_valid, r0_resp_rdata, r1_resp_rdata);
    end
    @(negedge clk); rst = 0; drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_write_alone();
    @(negedge clk); drive(1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0); #1;
    n_tests++;
    if (mem_we !== 1'b1 || mem_addr1 !== 5'd3 || mem_addr2 !== 5'd3 || mem_wd1 !== 32'hDEADBEEF || r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      n_fail++; $display("FAIL write_alone_ports: got we=%b a1=%0d a2=%0d wd1=%h rdy=%b%b, want 1 3 3 deadbeef 10", mem_we, mem_addr1, mem_addr2, mem_wd1, r0_ready, r1_ready);
    end
    @(posedge clk); #1;
    ref_mem[3] = 32'hDEADBEEF;
    n_tests++;
    if (r0_resp_valid !== 1'b1 || r0_resp_rdata !== '0 || r1_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL write_alone_resp: got v0=%b rd0=%h v1=%b, want 1 0 0", r0_resp_valid, r0_resp_rdata, r1_resp_valid);
    end
  endtask

  task automatic test_dual_read();
    @(negedge clk); drive(1, 0, 3, 0, 1, 0, 7, 0); #1;
    n_tests++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr1 !== 5'd3 || mem_addr2 !== 5'd7) begin
      n_fail++; $display("FAIL dual_read_grant: got rdy=%b%b we=%b a1=%0d a2=%0d, want 11 0 3 7", r0_ready, r1_ready, mem_we, mem_addr1, mem_addr2);
    end
    @(posedge clk); #1;
    n_tests++;
    if (r0_resp_valid !== 1'b1 || r1_resp_valid !== 1'b1 || r0_resp_rdata !== ref_mem[3] || r1_resp_rdata !== ref_mem[7]) begin
      n_fail++; $display("FAIL dual_read_data: got v=%b%b rd0=%h rd1=%h, want 11 %h %h", r0_resp_valid, r1_resp_valid, r0_resp_rdata, r1_resp_rdata, ref_mem[3], ref_mem[7]);
    end
  endtask

  task automatic test_conflict();
    bit exp0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(1, 1, 1, 32'h11, 1, 1, 1, 32'h22); #1;
      exp0 = (i % 2 == 0);
      n_tests++;
      if (r0_ready !== exp0 || r1_ready !== !exp0 || mem_we !== 1'b1) begin
        n_fail++; $display("FAIL conflict_turn%0d: got rdy=%b%b we=%b, want %b%b 1", i, r0_ready, r1_ready, mem_we, exp0, !exp0);
      end
      @(posedge clk);
    end
    ref_mem[1] = 32'h22;
    @(negedge clk); drive(1, 0, 1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    n_tests++;
    if (r0_resp_valid !== 1'b1 || r0_resp_rdata !== 32'h22) begin
      n_fail++; $display("FAIL conflict_final_read: got v=%b rd=%h, want 1 00000022", r0_resp_valid, r0_resp_rdata);
    end
  endtask

  task automatic test_mixed();
    @(negedge clk); drive(1, 1, 9, 32'h1, 1, 1, 10, 32'h2); #1;
    n_tests++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      n_fail++; $display("FAIL mixed_setup: got rdy=%b%b, want 10", r0_ready, r1_ready);
    end
    @(negedge clk); drive(0, 0, 0, 0, 1, 1, 10, 32'h2);
    @(negedge clk); drive(1, 0, 5, 0, 1, 1, 5, 32'hAA); #1;
    n_tests++;
    if (r0_ready !== 1'b0 || r1_ready !== 1'b1 || mem_addr1 !== 5'd5 || mem_wd1 !== 32'hAA) begin
      n_fail++; $display("FAIL mixed_r1_first: got rdy=%b%b a1=%0d wd1=%h, want 01 5 000000aa", r0_ready, r1_ready, mem_addr1, mem_wd1);
    end
    @(negedge clk); drive(1, 0, 5, 0, 0, 0, 0, 0); #1;
    n_tests++;
    if (r0_ready !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL mixed_r0_next: got r0_ready=%b we=%b, want 1 0", r0_ready, mem_we);
    end
    @(posedge clk); #1;
    ref_mem[9] = 32'h1; ref_mem[10] = 32'h2; ref_mem[5] = 32'hAA;
    n_tests++;
    if (r0_resp_valid !== 1'b1 || r0_resp_rdata !== 32'hAA) begin
      n_fail++; $display("FAIL mixed_read_after_write: got v=%b rd=%h, want 1 000000aa", r0_resp_valid, r0_resp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(1, 1, 20, 32'h7, 1, 1, 21, 32'h8);
    @(negedge clk); drive(0, 0, 0, 0, 1, 1, 21, 32'h8);
    ref_mem[20] = 32'h7; ref_mem[21] = 32'h8;
    @(negedge clk); drive(1, 0, 7, 0, 0, 0, 0, 0); #1;
    n_tests++;
    if (r0_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_accept: got r0_ready=%b, want 1", r0_ready);
    end
    @(negedge clk); rst = 1; drive(1, 1, 22, 32'h9, 1, 1, 23, 32'hA); #1;
    n_tests++;
    if (r0_resp_valid !== 1'b1 || r0_resp_rdata !== ref_mem[7] || r0_ready !== 1'b0 || r1_ready !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_during: got v=%b rd=%h rdy=%b%b we=%b, want 1 %h 00 0", r0_resp_valid, r0_resp_rdata, r0_ready, r1_ready, mem_we, ref_mem[7]);
    end
    @(posedge clk); #1;
    n_tests++;
    if (r0_resp_valid !== 1'b0 || r1_resp_valid !== 1'b0 || r0_resp_rdata !== '0) begin
      n_fail++; $display("FAIL rstmid_dropped: got v=%b%b rd0=%h, want 00 0", r0_resp_valid, r1_resp_valid, r0_resp_rdata);
    end
    @(negedge clk); rst = 0; #1;
    n_tests++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_prio_reset: got rdy=%b%b, want 10", r0_ready, r1_ready);
    end
    @(negedge clk); drive(1, 1, 24, 32'hB, 1, 1, 23, 32'hA); #1;
    n_tests++;
    if (r0_ready !== 1'b0 || r1_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_alternate: got rdy=%b%b, want 01", r0_ready, r1_ready);
    end
    @(negedge clk); drive(1, 1, 24, 32'hB, 0, 0, 0, 0);
    @(posedge clk); #1;
    ref_mem[22] = 32'h9; ref_mem[23] = 32'hA; ref_mem[24] = 32'hB;
  endtask

  task automatic test_stall_hold();
    int start;
    @(negedge clk); start = we_pulses; drive(1, 1, 12, 32'h33, 1, 1, 13, 32'h44); #1;
    n_tests++;
    if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_first: got rdy=%b%b, want 10", r0_ready, r1_ready);
    end
    @(negedge clk); drive(0, 0, 0, 0, 1, 1, 13, 32'h44); #1;
    n_tests++;
    if (r1_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr1 !== 5'd13 || mem_addr2 !== 5'd13 || mem_wd2 !== 32'h44) begin
      n_fail++; $display("FAIL stall_accept: got rdy1=%b we=%b a=%0d/%0d wd2=%h, want 1 1 13/13 00000044", r1_ready, mem_we, mem_addr1, mem_addr2, mem_wd2);
    end
    @(posedge clk); #1;
    ref_mem[12] = 32'h33; ref_mem[13] = 32'h44;
    n_tests++;
    if (we_pulses - start !== 2) begin
      n_fail++; $display("FAIL stall_we_pulses: got %0d, want 2", we_pulses - start);
    end
  endtask

  task automatic test_random();
    bit p0 = 0, p1 = 0, w0, w1, pm, e0, e1, conf;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1, x0, x1;
    @(negedge clk); rst = 1; drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 0;
    pm = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!p0 && $urandom_range(0, 9) < 6) begin
        p0 = 1; w0 = $urandom_range(0, 2) == 0; a0 = AW'($urandom_range(0, 7)); d0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 9) < 6) begin
        p1 = 1; w1 = $urandom_range(0, 2) == 0; a1 = AW'($urandom_range(0, 7)); d1 = $urandom;
      end
      drive(p0, w0, a0, d0, p1, w1, a1, d1); #1;
      conf = p0 && p1 && (w0 || w1);
      e0 = p0 && !(conf && pm);
      e1 = p1 && !(conf && !pm);
      x0 = w0 ? '0 : ref_mem[a0];
      x1 = w1 ? '0 : ref_mem[a1];
      n_tests++;
      if (r0_ready !== e0 || r1_ready !== e1 || mem_we !== ((e0 && w0) || (e1 && w1))) begin
        n_fail++; $display("FAIL rand_grant c%0d: got rdy=%b%b we=%b, want %b%b %b", c, r0_ready, r1_ready, mem_we, e0, e1, (e0 && w0) || (e1 && w1));
      end
      @(posedge clk); #1;
      n_tests++;
      if (r0_resp_valid !== e0 || r1_resp_valid !== e1 || (e0 && r0_resp_rdata !== x0) || (e1 && r1_resp_rdata !== x1)) begin
        n_fail++; $display("FAIL rand_resp c%0d: got v=%b%b rd0=%h rd1=%h, want %b%b %h %h", c, r0_resp_valid, r1_resp_valid, r0_resp_rdata, r1_resp_rdata, e0, e1, x0, x1);
      end
      if (e0 && w0) ref_mem[a0] = d0;
      if (e1 && w1) ref_mem[a1] = d1;
      if (conf) pm = !pm;
      if (e0) p0 = 0;
      if (e1) p1 = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = '0; ref_mem[i] = '0;
    end
    mem[7] = 32'h12345678; ref_mem[7] = 32'h12345678;
    rst = 1; drive(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_write_alone();
    test_dual_read();
    test_conflict();
    test_mixed();
    test_reset_mid();
    test_stall_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the dual-port `DataMemory` between two requesters: requester 0 is the core load/store unit, requester 1 is the debug/DMA loader. Each requester uses a valid/ready request channel and a fixed one-cycle response. The block drives the memory's two address ports and its single write enable. Reads are packed two per cycle where possible. Writes, which commit on both memory ports at once, get exclusive cycles under round-robin priority.

## Interface
- `ADDR_WIDTH`, 5, word address width; must match `DataMemory`.
- `DATA_WIDTH`, 32, data word width.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `r0_valid` / `r1_valid`  in  1  request valid.
- `r0_ready` / `r1_ready`  out  1  request accepted this cycle; combinational from valids, request fields and priority pointer.
- `r0_we` / `r1_we`  in  1  1 = write, 0 = read.
- `r0_addr` / `r1_addr`  in  ADDR_WIDTH  word address.
- `r0_wdata` / `r1_wdata`  in  DATA_WIDTH  write data.
- `r0_resp_valid` / `r1_resp_valid`  out  1  response strobe, one cycle after acceptance.
- `r0_resp_rdata` / `r1_resp_rdata`  out  DATA_WIDTH  read data; 0 for write responses.
- `mem_addr1`, `mem_addr2`  out  ADDR_WIDTH  to `DataMemory` `ADDR1`/`ADDR2`.
- `mem_wd1`, `mem_wd2`  out  DATA_WIDTH  to `WD1`/`WD2`.
- `mem_we`  out  1  to `WE`.
- `mem_rd1`, `mem_rd2`  in  DATA_WIDTH  from `RD1`/`RD2`.

## Operation
- Request transfer occurs on `rX_valid && rX_ready`. A requester holds all fields stable while `valid && !ready`. Valid is never withdrawn before acceptance.
- The grant decision is combinational each cycle from valids, `we` bits and priority pointer `prio` (1 bit, 0 = r0 favoured).
  - **Neither valid:** no grant; `mem_we=0`; mem addresses and wdata 0.
  - **Both valid, both reads (dual-read):** both granted.
    - r0 → port 1 (`mem_addr1=r0_addr`); r1 → port 2 (`mem_addr2=r1_addr`).
    - `prio` unchanged.
  - **Exactly one valid:** that requester is granted.
    - Read: addresses go to its own port (r0 → port 1, r1 → port 2); the other port is driven 0.
    - Write: follows the write rule below.
  - **Both valid, at least one write:** conflict. The requester selected by `prio` is granted alone; `prio` toggles to the loser.
- Write rule: `mem_addr1=mem_addr2=addr`, `mem_wd1=mem_wd2=wdata`, `mem_we=1`. Both memory ports are consumed, so no read shares a write cycle.
- `prio` changes only on conflict cycles. An uncontended write or read leaves it unchanged.
- Response register, per requester: `resp_valid <= accepted`.
  - Read: `resp_rdata <=` its port's `mem_rdN`.
  - Write: `resp_rdata <= 0`.
  - No accept: `resp_valid <= 0`; `resp_rdata` holds.
- The response channel has no backpressure; requesters always sink responses.
- Ordering: a write accepted in cycle N is visible to any read accepted in cycle N+1 or later. This holds because memory commits at the edge ending cycle N and reads are combinational.

## Timing
- Reset values: `prio=0`, `r0/r1_resp_valid=0`, `r0/r1_resp_rdata=0`. Combinational outputs follow from inputs with the reset `prio`.
- Latency: request accepted in cycle N → response in cycle N+1, exactly one cycle.
- Throughput:
  - Two reads per cycle when both requesters read.
  - One write per cycle.
  - Reads and writes never share a cycle.
- Reset mid-operation: pending responses are dropped (`resp_valid=0` the cycle after `rst`). Requests presented during `rst` are not accepted (`ready=0`, `mem_we=0`).
- Same-address dual read: legal; both requesters receive identical data.
- Back-to-back conflicts alternate strictly r0, r1, r0, …; neither requester can be starved.

## Structure
- Package `dmem_arb_pkg`:
  - `typedef struct packed {logic valid; logic we; logic [ADDR_WIDTH-1:0] addr; logic [DATA_WIDTH-1:0] wdata;} dmem_req_t` (default widths 5/32).
  - `typedef enum logic [1:0] {GNT_NONE, GNT_R0, GNT_R1, GNT_BOTH} dmem_gnt_e`.
- Sub-module `dmem_arb_grant`: purely combinational. Maps (two `dmem_req_t`, `prio`) → `dmem_gnt_e` plus a conflict flag. The top level holds `prio`, the memory-port muxing and the response registers.
- Top-level RTL target: ~150–250 lines.

## Test plan
- Reset, then r0 writes addr 3 ← 0xDEADBEEF alone:
  - `mem_we=1`, `mem_addr1=mem_addr2=3`, `r0_ready=1`.
  - Next cycle: `r0_resp_valid=1`, rdata 0.
- Dual-read: r0 reads 3, r1 reads 7 (preloaded 0x12345678) in the same cycle:
  - Both ready.
  - Next cycle: `r0_resp_rdata=0xDEADBEEF`, `r1_resp_rdata=0x12345678`.
  - `prio` unchanged.
- Conflict: both write (r0: addr 1 ← 0x11, r1: addr 1 ← 0x22) continuously for 4 cycles:
  - Grants r0, r1, r0, r1.
  - A final read of addr 1 returns 0x22.
- Mixed: r0 reads 5 while r1 writes 5 ← 0xAA with `prio=1`:
  - r1 granted first.
  - r0 granted next cycle; its response is 0xAA.
- Reset mid-operation: assert `rst` in the cycle after a read is accepted:
  - `resp_valid=0` in the following cycle; `prio=0`.
  - No `mem_we` pulse while `rst` is high.
- Stall hold: r1 presents a write while losing a conflict:
  - Fields held stable; accepted the next cycle.
  - Exactly one `mem_we` pulse per accepted write (count = 2 for 2 writes).
